ex_issue_stage: RTL and testbench
=================================

// Module: ex_issue_stage
// PURPOSE
//  ID->EX pipeline register that feeds the ALU; buffers one decoded instruction.
//  Selects ALU operands (rs1/pc, rs2/imm) and forwards in-flight results (MEM, WB).
//  Valid/ready handshake on both sides; flush kills the held and incoming instruction.
// PARAMETERS
//  XLEN      32  datapath width
//  REG_AW    5   register address width
// PORTS
//  clk          in   1      clock, rising edge
//  rst_n        in   1      asynchronous active-low reset
//  flush        in   1      discard held + incoming instruction (branch/trap)
//  id_valid     in   1      decode presents instruction
//  id_ready     out  1      stage can accept
//  id_pc        in   XLEN   instruction PC
//  id_rs1_addr  in   REG_AW source 1 index
//  id_rs2_addr  in   REG_AW source 2 index
//  id_rs1_data  in   XLEN   regfile read 1
//  id_rs2_data  in   XLEN   regfile read 2
//  id_imm       in   XLEN   sign-extended immediate
//  id_op1_sel   in   1      0: rs1, 1: pc
//  id_op2_sel   in   1      0: rs2, 1: imm
//  id_alu_op    in   4      ALU opcode (pkg encoding)
//  id_rd_addr   in   REG_AW destination index
//  id_rd_we     in   1      destination write enable
//  mem_rd_we / mem_rd_addr / mem_rd_data  in  1/REG_AW/XLEN  EX/MEM result bus
//  wb_rd_we  / wb_rd_addr  / wb_rd_data   in  1/REG_AW/XLEN  MEM/WB result bus
//  ex_valid     out  1      instruction held for ALU
//  ex_ready     in   1      EX consumes this cycle
//  src_op1      out  XLEN   ALU operand 1
//  src_op2      out  XLEN   ALU operand 2
//  alu_op       out  4      ALU opcode
//  ex_pc / ex_rs2_data / ex_rd_addr / ex_rd_we  out  XLEN/XLEN/REG_AW/1  sideband to EX/MEM
// BEHAVIOUR
//  - Reset: ex_valid=0; all registered fields 0 (alu_op=ALU_ADD, src_op1=src_op2=0, ex_rd_we=0).
//  - id_ready = !ex_valid | ex_ready (combinational; also 1 during flush).
//  - Capture on id_valid & id_ready & !flush: all fields registered, ex_valid<=1 next edge.
//  - ex_valid & ex_ready & no capture -> ex_valid<=0. Neither fire -> hold all fields.
//  - flush=1: ex_valid<=0 next edge regardless of id_valid/ex_ready; fields don't care.
//  - Latency 1 cycle ID->EX; full throughput when ex_ready=1 continuously.
//  - src_op1 = op1_sel ? ex_pc : rs1_q; src_op2 = op2_sel ? imm_q : rs2_q; ex_rs2_data = rs2_q.
//    Outputs driven only from registers (mux of registered fields allowed, no id_* path).
//  - Forwarding at capture: for each source, if mem_rd_we & mem_rd_addr==rsN & rsN!=0 use
//    mem_rd_data; else if wb match use wb_rd_data; else id_rsN_data. MEM beats WB.
//  - Hold snoop: while ex_valid & !ex_ready, a wb match (rsN_q_addr!=0) overwrites rsN_q.
//  - x0 never forwarded; rs data for addr 0 taken as-is from id_rsN_data.
//  - Reset mid-transfer: ex_valid drops asynchronously; in-flight instruction lost.
// CONFIGURATION
//  EX_FWD_EN defined: forwarding + hold snoop as above.
//  EX_FWD_EN undefined: mem_*/wb_* ignored, id_rsN_data captured raw, no snoop;
//    hazards resolved by decode stalling. Port list identical in both builds.
// STRUCTURE
//  riscv_pkg: ALU opcode constants ALU_ADD=0 SUB=1 SLT=2 SLTU=3 SGE=4 SGEU=5 AND=6 OR=7
//    XOR=8 SEQ=9 SNE=10 SL=11 SR=12 SRA=13; OP1_RS1/OP1_PC, OP2_RS2/OP2_IMM selects.
//  Sub-module fwd_mux: (addr, regfile data, mem bus, wb bus) -> forwarded data; two instances.
// TESTING
//  1 rst_n=0 mid-run -> ex_valid=0, alu_op=0, src_op1=src_op2=0 immediately.
//  2 id: rs1=0x10,rs2=0x20,ALU_ADD, ex_ready=1 -> next cycle ex_valid=1, src_op1=0x10, src_op2=0x20.
//  3 op1_sel=1 pc=0x100, op2_sel=1 imm=0xFFFFFFFC -> src_op1=0x100, src_op2=0xFFFFFFFC.
//  4 rs1_addr=5, mem 5<=0xAA, wb 5<=0xBB -> src_op1=0xAA; rs1_addr=0 with mem 0 match -> raw data.
//  5 ex_ready=0 two cycles, id_valid=1 -> id_ready=0, outputs stable; wb write to rs2 -> rs2_q updated.
//  6 flush with id_valid=1, ex_valid=1 -> next cycle ex_valid=0, nothing captured.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V core constants: ALU opcodes and operand selects.
// Imported by ex_issue_stage and fwd_mux.
package riscv_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int REG_AW_DEF = 5;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLT  = 4'd2;
    localparam logic [3:0] ALU_SLTU = 4'd3;
    localparam logic [3:0] ALU_SGE  = 4'd4;
    localparam logic [3:0] ALU_SGEU = 4'd5;
    localparam logic [3:0] ALU_AND  = 4'd6;
    localparam logic [3:0] ALU_OR   = 4'd7;
    localparam logic [3:0] ALU_XOR  = 4'd8;
    localparam logic [3:0] ALU_SEQ  = 4'd9;
    localparam logic [3:0] ALU_SNE  = 4'd10;
    localparam logic [3:0] ALU_SL   = 4'd11;
    localparam logic [3:0] ALU_SR   = 4'd12;
    localparam logic [3:0] ALU_SRA  = 4'd13;

    localparam logic OP1_RS1 = 1'b0;
    localparam logic OP1_PC  = 1'b1;
    localparam logic OP2_RS2 = 1'b0;
    localparam logic OP2_IMM = 1'b1;

endpackage

// File: rtl/ex_issue_stage_fwd_mux.sv
// fwd_mux: picks MEM result, then WB result, then regfile data for one source.
// Ports: i_addr, i_rf_data, i_mem_*, i_wb_* -> o_data. Macro EX_FWD_EN enables.
module fwd_mux
    import riscv_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic [REG_AW-1:0] i_addr,
    input  logic [XLEN-1:0]   i_rf_data,
    input  logic              i_mem_we,
    input  logic [REG_AW-1:0] i_mem_addr,
    input  logic [XLEN-1:0]   i_mem_data,
    input  logic              i_wb_we,
    input  logic [REG_AW-1:0] i_wb_addr,
    input  logic [XLEN-1:0]   i_wb_data,
    output logic [XLEN-1:0]   o_data
);

`ifdef EX_FWD_EN
    logic w_nz;
    logic w_mem_hit;
    logic w_wb_hit;

    // x0 is hardwired zero, so a write to it must never be forwarded
    assign w_nz      = (i_addr != '0);
    assign w_mem_hit = i_mem_we & (i_mem_addr == i_addr) & w_nz;
    assign w_wb_hit  = i_wb_we & (i_wb_addr == i_addr) & w_nz;

    always_comb begin
        o_data = i_rf_data;
        if (w_mem_hit) begin
            o_data = i_mem_data;
        end else if (w_wb_hit) begin
            o_data = i_wb_data;
        end
    end
`else
    logic w_unused;

    // decode stalls on hazards in this build; result buses are ignored
    assign w_unused = ^{i_addr, i_mem_we, i_mem_addr, i_mem_data,
                        i_wb_we, i_wb_addr, i_wb_data};
    assign o_data   = i_rf_data;
`endif

endmodule

// File: rtl/ex_issue_stage.sv
// ID->EX register feeding the ALU: operand select, forwarding, valid/ready.
// Ports: ID side id_*, result buses mem_*/wb_*, EX side ex_*/src_*/alu_op. Macro EX_FWD_EN.
module ex_issue_stage
    import riscv_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [REG_AW-1:0] id_rs1_addr,
    input  logic [REG_AW-1:0] id_rs2_addr,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic              id_op1_sel,
    input  logic              id_op2_sel,
    input  logic [3:0]        id_alu_op,
    input  logic [REG_AW-1:0] id_rd_addr,
    input  logic              id_rd_we,
    input  logic              mem_rd_we,
    input  logic [REG_AW-1:0] mem_rd_addr,
    input  logic [XLEN-1:0]   mem_rd_data,
    input  logic              wb_rd_we,
    input  logic [REG_AW-1:0] wb_rd_addr,
    input  logic [XLEN-1:0]   wb_rd_data,
    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [XLEN-1:0]   src_op1,
    output logic [XLEN-1:0]   src_op2,
    output logic [3:0]        alu_op,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_rs2_data,
    output logic [REG_AW-1:0] ex_rd_addr,
    output logic              ex_rd_we
);

    logic              r_valid;
    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   r_rs1;
    logic [XLEN-1:0]   r_rs2;
    logic [XLEN-1:0]   r_imm;
    logic              r_op1_sel;
    logic              r_op2_sel;
    logic [3:0]        r_alu_op;
    logic [REG_AW-1:0] r_rd_addr;
    logic              r_rd_we;

    logic [XLEN-1:0]   w_rs1_fwd;
    logic [XLEN-1:0]   w_rs2_fwd;
    logic              w_capture;

    fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs1 (
        .i_addr     (id_rs1_addr),
        .i_rf_data  (id_rs1_data),
        .i_mem_we   (mem_rd_we),
        .i_mem_addr (mem_rd_addr),
        .i_mem_data (mem_rd_data),
        .i_wb_we    (wb_rd_we),
        .i_wb_addr  (wb_rd_addr),
        .i_wb_data  (wb_rd_data),
        .o_data     (w_rs1_fwd)
    );

    fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs2 (
        .i_addr     (id_rs2_addr),
        .i_rf_data  (id_rs2_data),
        .i_mem_we   (mem_rd_we),
        .i_mem_addr (mem_rd_addr),
        .i_mem_data (mem_rd_data),
        .i_wb_we    (wb_rd_we),
        .i_wb_addr  (wb_rd_addr),
        .i_wb_data  (wb_rd_data),
        .o_data     (w_rs2_fwd)
    );

    // flush frees the slot, so the stage reports ready while it is asserted
    assign id_ready  = !r_valid | ex_ready | flush;
    assign w_capture = id_valid & id_ready & !flush;

`ifdef EX_FWD_EN
    logic [REG_AW-1:0] r_rs1_addr;
    logic [REG_AW-1:0] r_rs2_addr;
    logic              w_hold;
    logic              w_snoop1;
    logic              w_snoop2;

    // a stalled instruction would miss a WB write that retires meanwhile
    assign w_hold   = r_valid & !ex_ready;
    assign w_snoop1 = w_hold & wb_rd_we & (wb_rd_addr == r_rs1_addr) & (r_rs1_addr != '0);
    assign w_snoop2 = w_hold & wb_rd_we & (wb_rd_addr == r_rs2_addr) & (r_rs2_addr != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rs1_addr <= '0;
            r_rs2_addr <= '0;
        end else if (w_capture) begin
            r_rs1_addr <= id_rs1_addr;
            r_rs2_addr <= id_rs2_addr;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid   <= 1'b0;
            r_pc      <= '0;
            r_rs1     <= '0;
            r_rs2     <= '0;
            r_imm     <= '0;
            r_op1_sel <= OP1_RS1;
            r_op2_sel <= OP2_RS2;
            r_alu_op  <= ALU_ADD;
            r_rd_addr <= '0;
            r_rd_we   <= 1'b0;
        end else begin
            if (flush) begin
                r_valid <= 1'b0;
            end else if (w_capture) begin
                r_valid <= 1'b1;
            end else if (ex_ready) begin
                r_valid <= 1'b0;
            end
            if (w_capture) begin
                r_pc      <= id_pc;
                r_rs1     <= w_rs1_fwd;
                r_rs2     <= w_rs2_fwd;
                r_imm     <= id_imm;
                r_op1_sel <= id_op1_sel;
                r_op2_sel <= id_op2_sel;
                r_alu_op  <= id_alu_op;
                r_rd_addr <= id_rd_addr;
                r_rd_we   <= id_rd_we;
            end
`ifdef EX_FWD_EN
            else begin
                if (w_snoop1) r_rs1 <= wb_rd_data;
                if (w_snoop2) r_rs2 <= wb_rd_data;
            end
`endif
        end
    end

    assign ex_valid    = r_valid;
    assign src_op1     = (r_op1_sel == OP1_PC)  ? r_pc  : r_rs1;
    assign src_op2     = (r_op2_sel == OP2_IMM) ? r_imm : r_rs2;
    assign alu_op      = r_alu_op;
    assign ex_pc       = r_pc;
    assign ex_rs2_data = r_rs2;
    assign ex_rd_addr  = r_rd_addr;
    assign ex_rd_we    = r_rd_we;

endmodule

// File: tb/tb_ex_issue_stage.sv
// Self-checking bench for ex_issue_stage: directed scenarios plus random
// traffic checked against a transaction-level model.
module tb_ex_issue_stage;

`ifdef EX_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [4:0]  id_rs1_addr;
    logic [4:0]  id_rs2_addr;
    logic [31:0] id_rs1_data;
    logic [31:0] id_rs2_data;
    logic [31:0] id_imm;
    logic        id_op1_sel;
    logic        id_op2_sel;
    logic [3:0]  id_alu_op;
    logic [4:0]  id_rd_addr;
    logic        id_rd_we;
    logic        mem_rd_we;
    logic [4:0]  mem_rd_addr;
    logic [31:0] mem_rd_data;
    logic        wb_rd_we;
    logic [4:0]  wb_rd_addr;
    logic [31:0] wb_rd_data;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] src_op1;
    logic [31:0] src_op2;
    logic [3:0]  alu_op;
    logic [31:0] ex_pc;
    logic [31:0] ex_rs2_data;
    logic [4:0]  ex_rd_addr;
    logic        ex_rd_we;

    int n_checks = 0;
    int n_fail   = 0;

    ex_issue_stage dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_op1_sel(id_op1_sel), .id_op2_sel(id_op2_sel),
        .id_alu_op(id_alu_op), .id_rd_addr(id_rd_addr), .id_rd_we(id_rd_we),
        .mem_rd_we(mem_rd_we), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .wb_rd_we(wb_rd_we), .wb_rd_addr(wb_rd_addr), .wb_rd_data(wb_rd_data),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .src_op1(src_op1), .src_op2(src_op2), .alu_op(alu_op),
        .ex_pc(ex_pc), .ex_rs2_data(ex_rs2_data),
        .ex_rd_addr(ex_rd_addr), .ex_rd_we(ex_rd_we)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle();
        flush       = 1'b0;
        id_valid    = 1'b0;
        ex_ready    = 1'b1;
        id_pc       = '0;
        id_rs1_addr = '0;
        id_rs2_addr = '0;
        id_rs1_data = '0;
        id_rs2_data = '0;
        id_imm      = '0;
        id_op1_sel  = 1'b0;
        id_op2_sel  = 1'b0;
        id_alu_op   = 4'd0;
        id_rd_addr  = '0;
        id_rd_we    = 1'b0;
        mem_rd_we   = 1'b0;
        mem_rd_addr = '0;
        mem_rd_data = '0;
        wb_rd_we    = 1'b0;
        wb_rd_addr  = '0;
        wb_rd_data  = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        #3;
        n_checks++;
        if (ex_valid !== 1'b0 || alu_op !== 4'd0 || src_op1 !== 32'd0 ||
            src_op2 !== 32'd0 || ex_rd_we !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: v=%b op=%h s1=%h s2=%h we=%b want 0", ex_valid, alu_op, src_op1, src_op2, ex_rd_we);
        end
        n_checks++;
        if (id_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b want 1", id_ready);
        end
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid();
        idle();
        id_valid    = 1'b1;
        id_rs1_data = 32'h1234;
        id_rs2_data = 32'h5678;
        id_alu_op   = 4'd7;
        id_rd_we    = 1'b1;
        id_rd_addr  = 5'd3;
        tick();
        idle();
        n_checks++;
        if (ex_valid !== 1'b1 || src_op1 !== 32'h1234) begin
            n_fail++;
            $display("FAIL reset_mid_pre: v=%b s1=%h want 1/1234", ex_valid, src_op1);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (ex_valid !== 1'b0 || alu_op !== 4'd0 || src_op1 !== 32'd0 ||
            src_op2 !== 32'd0 || ex_rd_we !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: v=%b op=%h s1=%h s2=%h we=%b want 0", ex_valid, alu_op, src_op1, src_op2, ex_rd_we);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        idle();
        id_valid    = 1'b1;
        id_rs1_addr = 5'd1;
        id_rs2_addr = 5'd2;
        id_rs1_data = 32'h10;
        id_rs2_data = 32'h20;
        id_alu_op   = 4'd0;
        id_rd_addr  = 5'd4;
        id_rd_we    = 1'b1;
        tick();
        idle();
        n_checks++;
        if (ex_valid !== 1'b1 || src_op1 !== 32'h10 || src_op2 !== 32'h20 ||
            alu_op !== 4'd0 || ex_rd_addr !== 5'd4 || ex_rd_we !== 1'b1) begin
            n_fail++;
            $display("FAIL basic: v=%b s1=%h s2=%h op=%h rd=%0d we=%b want 1/10/20/0/4/1", ex_valid, src_op1, src_op2, alu_op, ex_rd_addr, ex_rd_we);
        end
        tick();
        n_checks++;
        if (ex_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_drain: ex_valid=%b want 0", ex_valid);
        end
    endtask

    task automatic test_sel();
        idle();
        id_valid    = 1'b1;
        id_pc       = 32'h100;
        id_imm      = 32'hFFFF_FFFC;
        id_rs1_data = 32'h11;
        id_rs2_data = 32'h33;
        id_op1_sel  = 1'b1;
        id_op2_sel  = 1'b1;
        id_alu_op   = 4'd1;
        tick();
        idle();
        n_checks++;
        if (src_op1 !== 32'h100 || src_op2 !== 32'hFFFF_FFFC || ex_pc !== 32'h100 ||
            ex_rs2_data !== 32'h33 || alu_op !== 4'd1) begin
            n_fail++;
            $display("FAIL sel: s1=%h s2=%h pc=%h rs2=%h op=%h want 100/fffffffc/100/33/1", src_op1, src_op2, ex_pc, ex_rs2_data, alu_op);
        end
        tick();
    endtask

    task automatic test_fwd();
        idle();
        id_valid    = 1'b1;
        id_rs1_addr = 5'd5;
        id_rs2_addr = 5'd5;
        id_rs1_data = 32'h11;
        id_rs2_data = 32'h12;
        mem_rd_we   = 1'b1;
        mem_rd_addr = 5'd5;
        mem_rd_data = 32'hAA;
        wb_rd_we    = 1'b1;
        wb_rd_addr  = 5'd5;
        wb_rd_data  = 32'hBB;
        tick();
        n_checks++;
        if (src_op1 !== (FWD ? 32'hAA : 32'h11) || src_op2 !== (FWD ? 32'hAA : 32'h12)) begin
            n_fail++;
            $display("FAIL fwd_mem_priority: s1=%h s2=%h want %h/%h", src_op1, src_op2, FWD ? 32'hAA : 32'h11, FWD ? 32'hAA : 32'h12);
        end
        id_rs1_addr = 5'd0;
        id_rs1_data = 32'h22;
        id_rs2_addr = 5'd6;
        id_rs2_data = 32'h44;
        mem_rd_addr = 5'd0;
        mem_rd_data = 32'h77;
        wb_rd_addr  = 5'd6;
        wb_rd_data  = 32'hBB;
        tick();
        idle();
        n_checks++;
        if (src_op1 !== 32'h22) begin
            n_fail++;
            $display("FAIL fwd_x0: s1=%h want 22", src_op1);
        end
        n_checks++;
        if (src_op2 !== (FWD ? 32'hBB : 32'h44)) begin
            n_fail++;
            $display("FAIL fwd_wb: s2=%h want %h", src_op2, FWD ? 32'hBB : 32'h44);
        end
        tick();
    endtask

    task automatic test_hold();
        idle();
        id_valid    = 1'b1;
        id_rs1_addr = 5'd8;
        id_rs2_addr = 5'd9;
        id_rs1_data = 32'h40;
        id_rs2_data = 32'h50;
        id_alu_op   = 4'd6;
        tick();
        ex_ready    = 1'b0;
        id_rs1_data = 32'h99;
        id_rs2_data = 32'h98;
        id_alu_op   = 4'd8;
        #1;
        n_checks++;
        if (id_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_ready: id_ready=%b want 0", id_ready);
        end
        tick();
        n_checks++;
        if (ex_valid !== 1'b1 || src_op1 !== 32'h40 || src_op2 !== 32'h50 || alu_op !== 4'd6) begin
            n_fail++;
            $display("FAIL hold_stable: v=%b s1=%h s2=%h op=%h want 1/40/50/6", ex_valid, src_op1, src_op2, alu_op);
        end
        wb_rd_we   = 1'b1;
        wb_rd_addr = 5'd9;
        wb_rd_data = 32'hCC;
        tick();
        wb_rd_we = 1'b0;
        n_checks++;
        if (ex_valid !== 1'b1 || ex_rs2_data !== (FWD ? 32'hCC : 32'h50) ||
            src_op2 !== (FWD ? 32'hCC : 32'h50) || src_op1 !== 32'h40) begin
            n_fail++;
            $display("FAIL hold_snoop: v=%b rs2=%h s2=%h s1=%h want rs2 %h", ex_valid, ex_rs2_data, src_op2, src_op1, FWD ? 32'hCC : 32'h50);
        end
        ex_ready = 1'b1;
        tick();
        idle();
        n_checks++;
        if (ex_valid !== 1'b1 || src_op1 !== 32'h99 || alu_op !== 4'd8) begin
            n_fail++;
            $display("FAIL hold_release: v=%b s1=%h op=%h want 1/99/8", ex_valid, src_op1, alu_op);
        end
        tick();
    endtask

    task automatic test_flush();
        idle();
        id_valid    = 1'b1;
        id_rs1_data = 32'h5;
        tick();
        ex_ready    = 1'b0;
        flush       = 1'b1;
        id_rs1_data = 32'h6;
        #1;
        n_checks++;
        if (id_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_ready: id_ready=%b want 1", id_ready);
        end
        tick();
        n_checks++;
        if (ex_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_kill: ex_valid=%b want 0", ex_valid);
        end
        idle();
        tick();
        n_checks++;
        if (ex_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_nocap: ex_valid=%b want 0", ex_valid);
        end
    endtask

    task automatic test_back_to_back();
        idle();
        id_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            id_rs1_data = 32'hA000 + i;
            tick();
            n_checks++;
            if (ex_valid !== 1'b1 || src_op1 !== 32'hA000 + i || id_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b[%0d]: v=%b s1=%h rdy=%b want 1/%h/1", i, ex_valid, src_op1, id_ready, 32'hA000 + i);
            end
        end
        idle();
        tick();
    endtask

    function automatic logic [31:0] fwd_ref(input logic [4:0] a, input logic [31:0] raw);
        if (!FWD || a == 5'd0) return raw;
        if (mem_rd_we && mem_rd_addr == a) return mem_rd_data;
        if (wb_rd_we && wb_rd_addr == a) return wb_rd_data;
        return raw;
    endfunction

    task automatic test_random();
        bit          m_v = 1'b0;
        logic [31:0] m_pc, m_r1, m_r2, m_imm;
        logic [4:0]  m_a1, m_a2, m_rd;
        logic        m_s1, m_s2, m_we;
        logic [3:0]  m_op;
        logic        e_rdy;
        logic [31:0] e1, e2;
        idle();
        for (int c = 0; c < 400; c++) begin
            flush       = ($urandom_range(0, 15) == 0);
            id_valid    = $urandom_range(0, 3) != 0;
            ex_ready    = $urandom_range(0, 2) != 0;
            id_pc       = $urandom;
            id_rs1_addr = 5'($urandom_range(0, 3));
            id_rs2_addr = 5'($urandom_range(0, 3));
            id_rs1_data = $urandom;
            id_rs2_data = $urandom;
            id_imm      = $urandom;
            id_op1_sel  = 1'($urandom);
            id_op2_sel  = 1'($urandom);
            id_alu_op   = 4'($urandom_range(0, 13));
            id_rd_addr  = 5'($urandom);
            id_rd_we    = 1'($urandom);
            mem_rd_we   = 1'($urandom);
            mem_rd_addr = 5'($urandom_range(0, 3));
            mem_rd_data = $urandom;
            wb_rd_we    = 1'($urandom);
            wb_rd_addr  = 5'($urandom_range(0, 3));
            wb_rd_data  = $urandom;
            #1;
            e_rdy = !m_v || ex_ready || flush;
            n_checks++;
            if (id_ready !== e_rdy) begin
                n_fail++;
                $display("FAIL rnd_ready[%0d]: got %b want %b", c, id_ready, e_rdy);
            end
            if (flush) begin
                m_v = 1'b0;
            end else if (id_valid && e_rdy) begin
                m_v   = 1'b1;
                m_pc  = id_pc;
                m_a1  = id_rs1_addr;
                m_a2  = id_rs2_addr;
                m_r1  = fwd_ref(id_rs1_addr, id_rs1_data);
                m_r2  = fwd_ref(id_rs2_addr, id_rs2_data);
                m_imm = id_imm;
                m_s1  = id_op1_sel;
                m_s2  = id_op2_sel;
                m_op  = id_alu_op;
                m_rd  = id_rd_addr;
                m_we  = id_rd_we;
            end else if (m_v && !ex_ready) begin
                if (FWD && wb_rd_we && wb_rd_addr == m_a1 && m_a1 != 0) m_r1 = wb_rd_data;
                if (FWD && wb_rd_we && wb_rd_addr == m_a2 && m_a2 != 0) m_r2 = wb_rd_data;
            end else begin
                m_v = 1'b0;
            end
            @(posedge clk);
            #1;
            n_checks++;
            if (ex_valid !== m_v) begin
                n_fail++;
                $display("FAIL rnd_valid[%0d]: got %b want %b", c, ex_valid, m_v);
            end
            if (m_v) begin
                e1 = m_s1 ? m_pc : m_r1;
                e2 = m_s2 ? m_imm : m_r2;
                n_checks++;
                if (src_op1 !== e1 || src_op2 !== e2 || alu_op !== m_op || ex_pc !== m_pc ||
                    ex_rs2_data !== m_r2 || ex_rd_addr !== m_rd || ex_rd_we !== m_we) begin
                    n_fail++;
                    $display("FAIL rnd_fields[%0d]: s1=%h/%h s2=%h/%h op=%h/%h rs2=%h/%h rd=%0d/%0d we=%b/%b",
                             c, src_op1, e1, src_op2, e2, alu_op, m_op, ex_rs2_data, m_r2, ex_rd_addr, m_rd, ex_rd_we, m_we);
                end
            end
        end
        idle();
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sel();
        test_fwd();
        test_hold();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
